// File: rtl/instr_line_cache.sv
// Direct-mapped instruction line cache in front of a MIG DDR3 user interface; optional INSTR_CACHE_STATS_EN adds hit/miss counters.
// Latency: hit 1 cycle after fetch_req; a miss costs one MIG read plus 1 cycle; a load finishes 1 cycle after both MIG handshakes.
// Backpressure: fetch_busy is high outside IDLE; app_en/app_wdf_wren are held until app_rdy/app_wdf_rdy accept them.
module instr_line_cache #(
    parameter int ADDR_WIDTH = 28,
    parameter int NUM_LINES  = 4
) (
    input  logic                  ui_clk,
    input  logic                  resetn,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_pc,
    output logic [31:0]           fetch_instr,
    output logic                  fetch_valid,
    output logic                  fetch_busy,
    input  logic                  ld_wr,
    input  logic [31:0]           ld_addr,
    input  logic [127:0]          ld_data,
    output logic                  ld_ack,
    input  logic                  calib_done,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic [127:0]          app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    output logic [127:0]          app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end
`ifdef INSTR_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = ADDR_WIDTH - 3 - IW;

    typedef enum logic [2:0] {CALIB, IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:2]   addr_q, addr_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
    logic [2:0]            app_cmd_q, app_cmd_d;
    logic                  app_en_q, app_en_d;
    logic                  wren_q, wren_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic [31:0]           fetch_instr_q, fetch_instr_d;
    logic                  ld_ack_q, ld_ack_d;

    logic [127:0]          line_q [NUM_LINES];
    logic [TW-1:0]         tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;

    logic                  line_we;
    logic [127:0]          line_wdata;
    logic                  clr_valid;
    logic                  hit_evt, miss_evt;

    logic [IW-1:0]         lk_idx, rq_idx;
    logic [TW-1:0]         lk_tag, rq_tag;
    logic                  lk_hit, rq_hit;
    logic [31:0]           lk_word;

    assign lk_idx  = fetch_pc[IW+3:4];
    assign lk_tag  = fetch_pc[ADDR_WIDTH:IW+4];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_word = line_q[lk_idx][{fetch_pc[3:2], 5'd0} +: 32];
    assign rq_idx  = addr_q[IW+3:4];
    assign rq_tag  = addr_q[ADDR_WIDTH:IW+4];
    assign rq_hit  = valid_q[rq_idx] && (tag_q[rq_idx] == rq_tag);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        app_addr_d    = app_addr_q;
        app_cmd_d     = app_cmd_q;
        app_en_d      = app_en_q;
        wren_d        = wren_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        ld_ack_d      = 1'b0;
        line_we       = 1'b0;
        line_wdata    = app_rd_data;
        clr_valid     = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;
        case (state_q)
            CALIB: begin
                if (calib_done) state_d = IDLE;
            end
            IDLE: begin
                if (ld_wr) begin
                    state_d    = WR_CMD;
                    addr_d     = ld_addr[ADDR_WIDTH:2];
                    wdata_d    = ld_data;
                    app_addr_d = {ld_addr[ADDR_WIDTH:4], 3'b000};
                    app_cmd_d  = 3'b000;
                    app_en_d   = 1'b1;
                    wren_d     = 1'b1;
                end else if (fetch_req) begin
                    if (lk_hit) begin
                        hit_evt       = 1'b1;
                        fetch_valid_d = 1'b1;
                        fetch_instr_d = lk_word;
                    end else begin
                        miss_evt   = 1'b1;
                        state_d    = RD_CMD;
                        addr_d     = fetch_pc[ADDR_WIDTH:2];
                        app_addr_d = {fetch_pc[ADDR_WIDTH:4], 3'b000};
                        app_cmd_d  = 3'b001;
                        app_en_d   = 1'b1;
                    end
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    app_en_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    line_we       = 1'b1;
                    fetch_valid_d = 1'b1;
                    fetch_instr_d = app_rd_data[{addr_q[3:2], 5'd0} +: 32];
                    state_d       = IDLE;
                end
            end
            WR_CMD: begin
                // Command and write data are accepted independently by the MIG.
                if (app_en_q && app_rdy)    app_en_d = 1'b0;
                if (wren_q && app_wdf_rdy)  wren_d   = 1'b0;
                if (!app_en_d && !wren_d) begin
                    ld_ack_d = 1'b1;
                    state_d  = IDLE;
                    if (rq_hit) begin
                        line_we    = 1'b1;
                        line_wdata = wdata_q;
                    end
                end
            end
            default: state_d = CALIB;
        endcase
        // Losing calibration abandons everything and invalidates the cache.
        if (!calib_done && state_q != CALIB) begin
            state_d       = CALIB;
            app_en_d      = 1'b0;
            wren_d        = 1'b0;
            fetch_valid_d = 1'b0;
            ld_ack_d      = 1'b0;
            line_we       = 1'b0;
            clr_valid     = 1'b1;
            hit_evt       = 1'b0;
            miss_evt      = 1'b0;
        end
    end

    always_ff @(posedge ui_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= CALIB;
            addr_q        <= '0;
            wdata_q       <= '0;
            app_addr_q    <= '0;
            app_cmd_q     <= 3'b000;
            app_en_q      <= 1'b0;
            wren_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= 32'd0;
            ld_ack_q      <= 1'b0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            app_addr_q    <= app_addr_d;
            app_cmd_q     <= app_cmd_d;
            app_en_q      <= app_en_d;
            wren_q        <= wren_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            ld_ack_q      <= ld_ack_d;
            if (clr_valid)    valid_q         <= '0;
            else if (line_we) valid_q[rq_idx] <= 1'b1;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (line_we) begin
            line_q[rq_idx] <= line_wdata;
            tag_q[rq_idx]  <= rq_tag;
        end
    end

`ifdef INSTR_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge ui_clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (hit_evt && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[31:ADDR_WIDTH+1], fetch_pc[1:0],
                           ld_addr[31:ADDR_WIDTH+1], ld_addr[1:0], hit_evt, miss_evt};

    assign fetch_instr  = fetch_instr_q;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_busy   = (state_q != IDLE);
    assign ld_ack       = ld_ack_q;
    assign app_addr     = app_addr_q;
    assign app_cmd      = app_cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = 1'b1;

endmodule

// File: tb/tb_instr_line_cache.sv
// Directed bench for instr_line_cache with a small MIG responder model.
module tb_instr_line_cache;
    localparam int AW = 28;
    localparam logic [127:0] LINE0    = {32'h01090018, 32'h212A000C, 32'h012A4023, 32'h012A4020};
    localparam logic [127:0] LINE40   = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    localparam logic [127:0] LINE_NEW = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    localparam logic [127:0] LINE10   = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
    localparam logic [127:0] LINE20   = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
    localparam logic [127:0] LINE30   = {32'hE0000003, 32'hE0000002, 32'hE0000001, 32'hE0000000};
    localparam logic [127:0] LINEX    = {32'hF0000003, 32'hF0000002, 32'hF0000001, 32'hF0000000};

    logic          ui_clk = 1'b0;
    logic          resetn;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_instr;
    logic          fetch_valid, fetch_busy;
    logic          ld_wr;
    logic [31:0]   ld_addr;
    logic [127:0]  ld_data;
    logic          ld_ack;
    logic          calib_done, app_rdy, app_wdf_rdy;
    logic [127:0]  app_rd_data;
    logic          app_rd_data_valid;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic [127:0]  app_wdf_data;
    logic          app_wdf_wren, app_wdf_end;
`ifdef INSTR_CACHE_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    int rd_lat = 2;
    bit rd_pend = 0;
    int rd_wait = 0;
    logic [AW-1:0] rd_addr, wr_addr_last;
    int rd_cnt = 0, wr_cnt = 0, wdf_cnt = 0, seq = 0, rd_seq = 0, wr_seq = 0;
    int fv_cnt = 0, ack_cnt = 0;
    logic [127:0] wdf_seen;
    logic [127:0] mem [logic [AW-1:0]];

    always #5 ui_clk = ~ui_clk;

    instr_line_cache #(.ADDR_WIDTH(AW), .NUM_LINES(4)) dut (
        .ui_clk(ui_clk), .resetn(resetn),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .fetch_valid(fetch_valid), .fetch_busy(fetch_busy),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .calib_done(calib_done), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end)
`ifdef INSTR_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // MIG responder: sees handshakes mid-cycle, drives read returns for the next edge.
    initial begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(negedge ui_clk);
            app_rd_data_valid = 1'b0;
            if (rd_pend) begin
                if (rd_wait == 0) begin
                    app_rd_data_valid = 1'b1;
                    app_rd_data = mem.exists(rd_addr) ? mem[rd_addr] : {4{32'hBAD00000}};
                    rd_pend = 0;
                end else begin
                    rd_wait--;
                end
            end
            if (app_en === 1'b1 && app_rdy) begin
                seq++;
                if (app_cmd == 3'b001) begin
                    rd_cnt++; rd_seq = seq; rd_pend = 1; rd_wait = rd_lat; rd_addr = app_addr;
                end else begin
                    wr_cnt++; wr_seq = seq; wr_addr_last = app_addr;
                end
            end
            if (app_wdf_wren === 1'b1 && app_wdf_rdy) begin
                wdf_cnt++; wdf_seen = app_wdf_data; mem[wr_addr_last] = app_wdf_data;
            end
            if (fetch_valid === 1'b1) fv_cnt++;
            if (ld_ack === 1'b1) ack_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge ui_clk); #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, output logic [31:0] data, output bit ok, output int cyc);
        fetch_req = 1'b1; fetch_pc = pc; ok = 0; data = '0; cyc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step(); cyc++;
            if (fetch_valid) begin ok = 1; data = fetch_instr; end
        end
        fetch_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [127:0] d, output bit ok);
        ld_wr = 1'b1; ld_addr = a; ld_data = d; ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (ld_ack) ok = 1;
        end
        ld_wr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1; fetch_req = 0; fetch_pc = 0; ld_wr = 0; ld_addr = 0; ld_data = 0;
        calib_done = 0; app_rdy = 0; app_wdf_rdy = 0;
        #2 resetn = 1'b0;
        repeat (3) step();
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", fetch_busy); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid got %b exp 0", fetch_valid); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ld_ack); end
        checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL reset_app_en got %b exp 0", app_en); end
        checks++; if (app_wdf_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", app_wdf_wren); end
        checks++; if (app_wdf_end !== 1'b1) begin errors++; $display("FAIL reset_wdf_end got %b exp 1", app_wdf_end); end
        checks++; if (fetch_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", fetch_instr); end
        checks++; if (app_addr !== '0) begin errors++; $display("FAIL reset_app_addr got %h exp 0", app_addr); end
        checks++; if (app_cmd !== 3'd0) begin errors++; $display("FAIL reset_app_cmd got %h exp 0", app_cmd); end
    endtask

    task automatic test_calib_hold();
        fetch_req = 1'b1; fetch_pc = 32'h8; resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL calib_busy cyc %0d got %b exp 1", i, fetch_busy); end
            checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL calib_app_en cyc %0d got %b exp 0", i, app_en); end
        end
        fetch_req = 1'b0; calib_done = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        step();
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL calib_to_idle got %b exp 0", fetch_busy); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL calib_no_fvalid got %b exp 0", fetch_valid); end
    endtask

    task automatic test_load();
        int w0, a0, d0;
        w0 = wr_cnt; a0 = ack_cnt; d0 = wdf_cnt;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        ld_wr = 1'b1; ld_addr = 32'h0; ld_data = LINE0;
        step();
        checks++; if (app_en !== 1'b1) begin errors++; $display("FAIL load_app_en got %b exp 1", app_en); end
        checks++; if (app_wdf_wren !== 1'b1) begin errors++; $display("FAIL load_wren got %b exp 1", app_wdf_wren); end
        checks++; if (app_cmd !== 3'b000) begin errors++; $display("FAIL load_cmd got %h exp 0", app_cmd); end
        checks++; if (app_addr !== '0) begin errors++; $display("FAIL load_addr got %h exp 0", app_addr); end
        checks++; if (app_wdf_data !== LINE0) begin errors++; $display("FAIL load_wdata got %h exp %h", app_wdf_data, LINE0); end
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", fetch_busy); end
        app_rdy = 1'b1;
        step();
        app_rdy = 1'b0;
        checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL load_en_drop got %b exp 0", app_en); end
        checks++; if (app_wdf_wren !== 1'b1) begin errors++; $display("FAIL load_wren_hold got %b exp 1", app_wdf_wren); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (app_wdf_wren !== 1'b1) begin errors++; $display("FAIL load_wren_wait %0d got %b exp 1", i, app_wdf_wren); end
            checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL load_early_ack %0d got %b exp 0", i, ld_ack); end
        end
        app_wdf_rdy = 1'b1;
        step();
        app_wdf_rdy = 1'b0; ld_wr = 1'b0;
        checks++; if (app_wdf_wren !== 1'b0) begin errors++; $display("FAIL load_wren_drop got %b exp 0", app_wdf_wren); end
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL load_ack got %b exp 1", ld_ack); end
        step();
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL load_ack_pulse got %b exp 0", ld_ack); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL load_idle got %b exp 0", fetch_busy); end
        checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL load_ack_count got %0d exp 1", ack_cnt - a0); end
        checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL load_cmd_count got %0d exp 1", wr_cnt - w0); end
        checks++; if (wdf_cnt - d0 != 1 || wdf_seen !== LINE0) begin errors++; $display("FAIL load_wdf got %0d %h exp 1 %h", wdf_cnt - d0, wdf_seen, LINE0); end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    endtask

    task automatic test_miss_fill();
        int r0, cyc; logic [31:0] d; bit ok;
        rd_lat = 20; r0 = rd_cnt;
        do_fetch(32'h8, d, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL fill_timeout got 0 exp 1"); end
        checks++; if (d !== 32'h212A000C) begin errors++; $display("FAIL fill_data got %h exp 212a000c", d); end
        checks++; if (cyc <= 20) begin errors++; $display("FAIL fill_latency got %0d exp >20", cyc); end
        fetch_req = 1'b1; fetch_pc = 32'hC;
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h01090018) begin errors++; $display("FAIL hit_0c got %b %h exp 1 01090018", fetch_valid, fetch_instr); end
        checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL hit_app_en got %b exp 0", app_en); end
        fetch_pc = 32'h0;
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h012A4020) begin errors++; $display("FAIL b2b_00 got %b %h exp 1 012a4020", fetch_valid, fetch_instr); end
        fetch_pc = 32'h4;
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h012A4023) begin errors++; $display("FAIL b2b_04 got %b %h exp 1 012a4023", fetch_valid, fetch_instr); end
        fetch_req = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL hit_end got %b exp 0", fetch_valid); end
        checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL fill_reads got %0d exp 1", rd_cnt - r0); end
    endtask

    task automatic test_conflict();
        int r0, cyc; logic [31:0] d; bit ok;
`ifdef INSTR_CACHE_STATS_EN
        logic [31:0] m0;
`endif
        calib_done = 1'b0; step(); calib_done = 1'b1; step();
        rd_lat = 2; mem[28'h20] = LINE40; r0 = rd_cnt;
`ifdef INSTR_CACHE_STATS_EN
        m0 = miss_count;
`endif
        do_fetch(32'h0, d, ok, cyc);
        checks++; if (!ok || d !== 32'h012A4020) begin errors++; $display("FAIL conf_a got %b %h exp 1 012a4020", ok, d); end
        do_fetch(32'h40, d, ok, cyc);
        checks++; if (!ok || d !== 32'hA0000000) begin errors++; $display("FAIL conf_b got %b %h exp 1 a0000000", ok, d); end
        do_fetch(32'h0, d, ok, cyc);
        checks++; if (!ok || d !== 32'h012A4020) begin errors++; $display("FAIL conf_c got %b %h exp 1 012a4020", ok, d); end
        checks++; if (rd_cnt - r0 != 3) begin errors++; $display("FAIL conf_reads got %0d exp 3", rd_cnt - r0); end
`ifdef INSTR_CACHE_STATS_EN
        checks++; if (miss_count - m0 != 32'd3) begin errors++; $display("FAIL conf_miss_count got %0d exp 3", miss_count - m0); end
`endif
    endtask

    task automatic test_write_through();
        int r0, cyc; logic [31:0] d; bit ok;
        r0 = rd_cnt;
        do_load(32'h0, LINE_NEW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wt_ack got 0 exp 1"); end
        do_fetch(32'h8, d, ok, cyc);
        checks++; if (!ok || d !== 32'hC0000002) begin errors++; $display("FAIL wt_data got %b %h exp 1 c0000002", ok, d); end
        checks++; if (rd_cnt != r0) begin errors++; $display("FAIL wt_reads got %0d exp 0", rd_cnt - r0); end
    endtask

    task automatic test_back_to_back_ld_fetch();
        int ack_c, fv_c, s0; logic [31:0] got;
        mem[28'h08] = LINE10; s0 = seq; ack_c = -1; fv_c = -1; got = '0;
        ld_wr = 1'b1; ld_addr = 32'h100; ld_data = LINEX;
        fetch_req = 1'b1; fetch_pc = 32'h10;
        for (int i = 0; i < 200 && fv_c < 0; i++) begin
            step();
            if (i == 0) begin
                checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL coll_busy got %b exp 1", fetch_busy); end
            end
            if (ld_ack) begin ack_c = i; ld_wr = 1'b0; end
            if (fetch_valid) begin fv_c = i; got = fetch_instr; fetch_req = 1'b0; end
        end
        ld_wr = 1'b0; fetch_req = 1'b0;
        checks++; if (ack_c < 0) begin errors++; $display("FAIL coll_ack got none exp one"); end
        checks++; if (fv_c <= ack_c) begin errors++; $display("FAIL coll_order got fv %0d ack %0d exp fv>ack", fv_c, ack_c); end
        checks++; if (!(wr_seq > s0 && rd_seq > wr_seq)) begin errors++; $display("FAIL coll_cmd_order got wr %0d rd %0d exp wr first", wr_seq, rd_seq); end
        checks++; if (got !== 32'hB0000000) begin errors++; $display("FAIL coll_data got %h exp b0000000", got); end
    endtask

    task automatic test_calib_drop();
        int r0, f0, cyc; logic [31:0] d; bit ok, seen;
        rd_lat = 30; mem[28'h10] = LINE20; r0 = rd_cnt; seen = 0;
        fetch_req = 1'b1; fetch_pc = 32'h20;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (rd_cnt != r0) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL drop_rd_cmd got 0 exp 1"); end
        repeat (3) step();
        calib_done = 1'b0; fetch_req = 1'b0; f0 = fv_cnt;
        step();
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b exp 1", fetch_busy); end
        checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL drop_app_en got %b exp 0", app_en); end
        calib_done = 1'b1;
        repeat (40) step();
        checks++; if (fv_cnt != f0) begin errors++; $display("FAIL drop_fvalid got %0d exp 0", fv_cnt - f0); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %b exp 0", fetch_busy); end
        rd_lat = 3;
        do_fetch(32'h20, d, ok, cyc);
        checks++; if (!ok || d !== 32'hD0000000) begin errors++; $display("FAIL drop_refetch got %b %h exp 1 d0000000", ok, d); end
        checks++; if (rd_cnt - r0 != 2) begin errors++; $display("FAIL drop_reads got %0d exp 2", rd_cnt - r0); end
        do_fetch(32'h8, d, ok, cyc);
        checks++; if (rd_cnt - r0 != 3 || d !== 32'hC0000002) begin errors++; $display("FAIL drop_inval got %0d %h exp 3 c0000002", rd_cnt - r0, d); end
    endtask

    task automatic test_reset_mid();
        int r0, f0, cyc; logic [31:0] d; bit ok, seen;
        rd_lat = 20; mem[28'h18] = LINE30; r0 = rd_cnt; seen = 0;
        fetch_req = 1'b1; fetch_pc = 32'h30;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (rd_cnt != r0) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_rd_cmd got 0 exp 1"); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (fetch_busy !== 1'b1 || app_en !== 1'b0) begin errors++; $display("FAIL rst_async got busy %b en %b exp 1 0", fetch_busy, app_en); end
        fetch_req = 1'b0;
        step();
        resetn = 1'b1; f0 = fv_cnt;
        repeat (40) step();
        checks++; if (fv_cnt != f0) begin errors++; $display("FAIL rst_discard got %0d exp 0", fv_cnt - f0); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_idle got %b exp 0", fetch_busy); end
        rd_lat = 2;
        do_fetch(32'h30, d, ok, cyc);
        checks++; if (!ok || d !== 32'hE0000000 || rd_cnt - r0 != 2) begin errors++; $display("FAIL rst_refetch got %b %h %0d exp 1 e0000000 2", ok, d, rd_cnt - r0); end
    endtask

    initial begin
        test_reset();
        test_calib_hold();
        test_load();
        test_miss_fill();
        test_conflict();
        test_write_through();
        test_back_to_back_ld_fetch();
        test_calib_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
